// File: rtl/xbar_out_credit_stage.sv
// rtl/xbar_out_credit_stage.sv - registered crossbar output stage with per-port, per-VC credit counters
module xbar_out_credit_stage #(
    parameter int NOC_ID = 0,
    parameter int P      = 5,
    parameter int V      = 4,
    parameter int Fw     = 36,
    parameter int B      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [P*Fw-1:0]   flit_in_all,
    input  logic [P-1:0]      flit_in_wr_all,
    input  logic [P*V-1:0]    flit_vc_all,
    input  logic [P*V-1:0]    credit_in_all,
    output logic [P*Fw-1:0]   flit_out_all,
    output logic [P-1:0]      flit_out_wr_all,
    output logic [P*V-1:0]    flit_out_vc_all,
    output logic [P*V-1:0]    vc_has_credit_all,
    output logic [P-1:0]      credit_err_all
);

    localparam int Bw = $clog2(B + 1);
    localparam logic [Bw-1:0] CNT_MAX = Bw'(B);

    if (NOC_ID < 0 || P < 1 || V < 1 || B < 1) begin : g_param_check
        $error("xbar_out_credit_stage: invalid parameterisation");
    end

    logic [P*Fw-1:0] r_flit_out;
    logic [P-1:0]    r_wr_out;
    logic [P*V-1:0]  r_vc_out;
    logic [P-1:0]    r_err;

    logic [P-1:0]    w_vc_onehot;
    logic [P*V-1:0]  w_under;
    logic [P*V-1:0]  w_over;
    logic [P-1:0]    w_err_set;

    for (genvar p = 0; p < P; p++) begin : g_port
        logic [V-1:0] w_vc;
        assign w_vc = flit_vc_all[p*V +: V];
        assign w_vc_onehot[p] = (w_vc != '0) && ((w_vc & (w_vc - V'(1))) == '0);

        // A zero-hot or multi-hot VC on a written flit is a protocol error of its own.
        assign w_err_set[p] = (|w_under[p*V +: V]) | (|w_over[p*V +: V])
                            | (flit_in_wr_all[p] & ~w_vc_onehot[p]);

        for (genvar v = 0; v < V; v++) begin : g_vc
            localparam int I = p*V + v;
            logic [Bw-1:0] r_cnt;
            logic [Bw-1:0] w_cnt_nxt;
            logic          w_dec;
            logic          w_inc;
            logic          w_u;
            logic          w_o;

            assign w_dec = flit_in_wr_all[p] & flit_vc_all[I] & w_vc_onehot[p];
            assign w_inc = credit_in_all[I];

            // Counter saturates at 0 and B; a blocked step is reported instead.
            always_comb begin
                w_cnt_nxt = r_cnt;
                w_u       = 1'b0;
                w_o       = 1'b0;
                case ({w_dec, w_inc})
                    2'b10: begin
                        if (r_cnt == '0) w_u = 1'b1;
                        else             w_cnt_nxt = r_cnt - Bw'(1);
                    end
                    2'b01: begin
                        if (r_cnt == CNT_MAX) w_o = 1'b1;
                        else                  w_cnt_nxt = r_cnt + Bw'(1);
                    end
                    default: w_cnt_nxt = r_cnt;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!reset) r_cnt <= CNT_MAX;
                else        r_cnt <= w_cnt_nxt;
            end

            assign w_under[I]           = w_u;
            assign w_over[I]            = w_o;
            assign vc_has_credit_all[I] = (r_cnt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flit_out <= '0;
            r_wr_out   <= '0;
            r_vc_out   <= '0;
            r_err      <= '0;
        end else begin
            r_wr_out <= flit_in_wr_all;
            r_err    <= r_err | w_err_set;
            for (int p = 0; p < P; p++) begin
                if (flit_in_wr_all[p]) begin
                    r_flit_out[p*Fw +: Fw] <= flit_in_all[p*Fw +: Fw];
                    r_vc_out[p*V +: V]     <= flit_vc_all[p*V +: V];
                end
            end
        end
    end

    assign flit_out_all    = r_flit_out;
    assign flit_out_wr_all = r_wr_out;
    assign flit_out_vc_all = r_vc_out;
    assign credit_err_all  = r_err;

endmodule

// File: tb/tb_xbar_out_credit_stage.sv
// tb/tb_xbar_out_credit_stage.sv - randomized and directed self-checking bench for xbar_out_credit_stage
module tb_xbar_out_credit_stage;

    localparam int P  = 5;
    localparam int V  = 4;
    localparam int Fw = 36;
    localparam int B  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [P*Fw-1:0]  flit_in_all;
    logic [P-1:0]     flit_in_wr_all;
    logic [P*V-1:0]   flit_vc_all;
    logic [P*V-1:0]   credit_in_all;
    logic [P*Fw-1:0]  flit_out_all;
    logic [P-1:0]     flit_out_wr_all;
    logic [P*V-1:0]   flit_out_vc_all;
    logic [P*V-1:0]   vc_has_credit_all;
    logic [P-1:0]     credit_err_all;

    always #5 clk = ~clk;

    xbar_out_credit_stage #(
        .NOC_ID(0), .P(P), .V(V), .Fw(Fw), .B(B)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flit_in_all      (flit_in_all),
        .flit_in_wr_all   (flit_in_wr_all),
        .flit_vc_all      (flit_vc_all),
        .credit_in_all    (credit_in_all),
        .flit_out_all     (flit_out_all),
        .flit_out_wr_all  (flit_out_wr_all),
        .flit_out_vc_all  (flit_out_vc_all),
        .vc_has_credit_all(vc_has_credit_all),
        .credit_err_all   (credit_err_all)
    );

    // Reference state: credits held as plain integers, flit/vc as last-written values.
    logic [P*Fw-1:0] m_flit;
    logic [P-1:0]    m_wr;
    logic [P*V-1:0]  m_vc;
    logic [P-1:0]    m_err;
    int              m_cnt [P][V];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [P*V-1:0] model_has_credit();
        logic [P*V-1:0] h;
        for (int p = 0; p < P; p++)
            for (int v = 0; v < V; v++)
                h[p*V+v] = (m_cnt[p][v] != 0);
        return h;
    endfunction

    task automatic model_clock();
        if (!reset) begin
            m_flit = '0; m_wr = '0; m_vc = '0; m_err = '0;
            for (int p = 0; p < P; p++)
                for (int v = 0; v < V; v++)
                    m_cnt[p][v] = B;
        end else begin
            for (int p = 0; p < P; p++) begin
                logic [V-1:0] vc;
                bit           wr;
                bit           valid;
                vc    = flit_vc_all[p*V +: V];
                wr    = flit_in_wr_all[p];
                valid = ($countones(vc) == 1);
                m_wr[p] = wr;
                if (wr) begin
                    m_flit[p*Fw +: Fw] = flit_in_all[p*Fw +: Fw];
                    m_vc[p*V +: V]     = vc;
                    if (!valid) m_err[p] = 1'b1;
                end
                for (int v = 0; v < V; v++) begin
                    int n;
                    n = m_cnt[p][v] + int'(credit_in_all[p*V+v]) - int'(wr && valid && vc[v]);
                    if (n < 0) begin m_err[p] = 1'b1; n = 0; end
                    if (n > B) begin m_err[p] = 1'b1; n = B; end
                    m_cnt[p][v] = n;
                end
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic [P*Fw-1:0] f, input logic [P-1:0] wr,
                        input logic [P*V-1:0] vc, input logic [P*V-1:0] cr);
        reset          = rst_n;
        flit_in_all    = f;
        flit_in_wr_all = wr;
        flit_vc_all    = vc;
        credit_in_all  = cr;
        @(posedge clk);
        model_clock();
        #1;
        check("flit_out", flit_out_all, m_flit);
        check("wr_out", flit_out_wr_all, m_wr);
        check("vc_out", flit_out_vc_all, m_vc);
        check("has_credit", vc_has_credit_all, model_has_credit());
        check("credit_err", credit_err_all, m_err);
    endtask

    function automatic logic [P*Fw-1:0] rnd_flit();
        logic [P*Fw-1:0] r;
        for (int i = 0; i < P*Fw; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, rnd_flit(), '0, '0, '0);
    endtask

    logic [P*V-1:0] vc_w;
    logic [P*V-1:0] cr_w;
    logic [P-1:0]   wr_w;

    initial begin
        reset = 1'b0; flit_in_all = '0; flit_in_wr_all = '0; flit_vc_all = '0; credit_in_all = '0;
        step(1'b0, '0, '0, '0, '0);
        step(1'b0, '0, '0, '0, '0);

        // Reset then idle
        idle(10);
        check("reset_has_credit", vc_has_credit_all, {P*V{1'b1}});
        check("reset_err", credit_err_all, '0);

        // Port 2 VC1: drain the downstream buffer with back-to-back writes
        vc_w = '0; vc_w[2*V+1] = 1'b1;
        for (int k = 0; k < B; k++) begin
            step(1'b1, rnd_flit(), P'(1) << 2, vc_w, '0);
            check("p2_wr_out", flit_out_wr_all[2], 1'b1);
            check("p2v1_has", vc_has_credit_all[2*V+1], (k == B-1) ? 1'b0 : 1'b1);
        end
        idle(1);

        // Credit return from zero, then simultaneous write and credit
        cr_w = '0; cr_w[2*V+1] = 1'b1;
        step(1'b1, rnd_flit(), '0, '0, cr_w);
        check("p2v1_has_after_credit", vc_has_credit_all[2*V+1], 1'b1);
        step(1'b1, rnd_flit(), P'(1) << 2, vc_w, cr_w);
        check("p2v1_has_wr_cr", vc_has_credit_all[2*V+1], 1'b1);
        check("p2_err_wr_cr", credit_err_all[2], 1'b0);
        idle(1);

        // Underflow on port 0 VC0, overflow on port 3 VC0
        vc_w = '0; vc_w[0] = 1'b1;
        for (int k = 0; k <= B; k++) step(1'b1, rnd_flit(), P'(1), vc_w, '0);
        check("p0_underflow_err", credit_err_all[0], 1'b1);
        check("p0_underflow_fwd", flit_out_wr_all[0], 1'b1);
        idle(3);
        check("p0_err_sticky", credit_err_all[0], 1'b1);
        check("p0v0_has_zero", vc_has_credit_all[0], 1'b0);
        cr_w = '0; cr_w[3*V] = 1'b1;
        step(1'b1, rnd_flit(), '0, '0, cr_w);
        check("p3_overflow_err", credit_err_all[3], 1'b1);
        check("p3v0_has", vc_has_credit_all[3*V], 1'b1);

        // Multi-hot VC on port 1
        vc_w = '0; vc_w[V +: V] = 4'b0110;
        step(1'b1, rnd_flit(), P'(1) << 1, vc_w, '0);
        check("p1_invalid_err", credit_err_all[1], 1'b1);
        check("p1_invalid_vc_out", flit_out_vc_all[V +: V], 4'b0110);
        check("p1_has_unchanged", vc_has_credit_all[V +: V], {V{1'b1}});
        // Zero-hot VC on port 4
        step(1'b1, rnd_flit(), P'(1) << 4, '0, '0);
        check("p4_zerohot_err", credit_err_all[4], 1'b1);

        // Reset mid-burst on all ports
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < P; p++) vc_w[p*V +: V] = V'(1) << $urandom_range(0, V-1);
            step(1'b1, rnd_flit(), '1, vc_w, '0);
        end
        step(1'b0, rnd_flit(), '1, vc_w, '0);
        check("rst_mid_wr", flit_out_wr_all, '0);
        check("rst_mid_has", vc_has_credit_all, {P*V{1'b1}});
        check("rst_mid_err", credit_err_all, '0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < P; p++) begin
                wr_w[p] = ($urandom_range(0, 99) < 45);
                if ($urandom_range(0, 19) == 0) vc_w[p*V +: V] = V'($urandom_range(0, (1 << V) - 1));
                else                            vc_w[p*V +: V] = V'(1) << $urandom_range(0, V-1);
                for (int v = 0; v < V; v++) cr_w[p*V+v] = ($urandom_range(0, 99) < 11);
            end
            step(($urandom_range(0, 249) != 0), rnd_flit(), wr_w, vc_w, cr_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
